// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one EX-stage ALU between two requesters,
// with a one-entry registered response buffer per requester.
module alu_share_arbiter #(
  parameter int unsigned TAGW = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [3:0]      req0_code,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [3:0]      req1_code,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_code,
  input  logic [31:0]     alu_result,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [31:0]     rsp0_result,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [31:0]     rsp1_result,
  output logic [TAGW-1:0] rsp1_tag,
  output logic [CNTW-1:0] op_count
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic            r_last_grant;
  logic            r_rsp0_valid;
  logic [DW-1:0]   r_rsp0_result;
  logic [TAGW-1:0] r_rsp0_tag;
  logic            r_rsp1_valid;
  logic [DW-1:0]   r_rsp1_result;
  logic [TAGW-1:0] r_rsp1_tag;
  logic [CNTW-1:0] r_op_count;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  // A port may issue only when its response slot is empty or draining this cycle.
  assign w_elig0 = !reset && req0_valid && (!r_rsp0_valid || rsp0_ready);
  assign w_elig1 = !reset && req1_valid && (!r_rsp1_valid || rsp1_ready);

  // On a tie the port that did not win last time is granted.
  assign w_gnt0 = w_elig0 && (!w_elig1 || r_last_grant);
  assign w_gnt1 = w_elig1 && (!w_elig0 || !r_last_grant);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Idle cycles present a deterministic add of zeros to the ALU.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_code = CW'(0);
    if (w_gnt0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_code = req0_code;
    end else if (w_gnt1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_code = req1_code;
    end
  end

  // Port 0 response buffer: fill wins over drain so back-to-back ops stay valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_tag    <= '0;
    end else if (w_gnt0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= alu_result;
      r_rsp0_tag    <= req0_tag;
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_tag    <= '0;
    end else if (w_gnt1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= alu_result;
      r_rsp1_tag    <= req1_tag;
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  // Reset value of last_grant makes port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_op_count   <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_grant <= w_gnt1;
      r_op_count   <= r_op_count + CNTW'(1);
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_tag    = r_rsp0_tag;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_tag    = r_rsp1_tag;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table for arbitration,
// hand sequences for backpressure/reset/wrap, and a response scoreboard.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_code, req1_code;
  logic [1:0]  req0_tag, req1_tag;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] alu_a, alu_b, alu_result, rsp0_result, rsp1_result;
  logic [3:0]  alu_code;
  logic [1:0]  rsp0_tag, rsp1_tag;
  logic [15:0] op_count;

  logic        req0_ready4, req1_ready4, rsp0_valid4, rsp1_valid4;
  logic [31:0] alu_a4, alu_b4, alu_result4, rsp0_result4, rsp1_result4;
  logic [3:0]  alu_code4;
  logic [1:0]  rsp0_tag4, rsp1_tag4;
  logic [3:0]  op_count4;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference ALU: 0000 add, 0001 sub, 0010 sll, 1001 signed slt, else xor.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] code);
    case (code)
      4'b0000: alu_f = a + b;
      4'b0001: alu_f = a - b;
      4'b0010: alu_f = a << b[4:0];
      4'b1001: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = a ^ b;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_a, alu_b, alu_code);
  assign alu_result4 = alu_f(alu_a4, alu_b4, alu_code4);

  alu_share_arbiter #(.TAGW(2), .CNTW(16)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_code(req0_code), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_code(req1_code), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
    .op_count(op_count)
  );

  alu_share_arbiter #(.TAGW(2), .CNTW(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready4), .req0_a(req0_a), .req0_b(req0_b),
    .req0_code(req0_code), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready4), .req1_a(req1_a), .req1_b(req1_b),
    .req1_code(req1_code), .req1_tag(req1_tag),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_code(alu_code4), .alu_result(alu_result4),
    .rsp0_valid(rsp0_valid4), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result4), .rsp0_tag(rsp0_tag4),
    .rsp1_valid(rsp1_valid4), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result4), .rsp1_tag(rsp1_tag4),
    .op_count(op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected {tag,result} queued at accept, compared at response handshake.
  logic [33:0] q0[$];
  logic [33:0] q1[$];

  always @(negedge clk) begin
    logic [33:0] e;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("sb0_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("sb0_result", rsp0_result, e[31:0]);
          chk("sb0_tag", 32'(rsp0_tag), 32'(e[33:32]));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("sb1_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("sb1_result", rsp1_result, e[31:0]);
          chk("sb1_tag", 32'(rsp1_tag), 32'(e[33:32]));
        end
      end
      if (req0_valid && req0_ready) q0.push_back({req0_tag, alu_f(req0_a, req0_b, req0_code)});
      if (req1_valid && req1_ready) q1.push_back({req1_tag, alu_f(req1_a, req1_b, req1_code)});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic v0, v1, rr0, rr1;
    logic e0, e1;
  } row_t;

  row_t tbl[10];
  logic [15:0] cnt_exp;

  initial begin
    // Arbitration vectors; entering with last grant = port 0.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_code = 4'b0000; req0_tag = 2'd2;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_code = 4'b0000; req1_tag = 2'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    @(negedge clk);
    chk("ready_in_reset", 32'(req0_ready), 32'd0);
    step();
    reset = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_rsp0_tag", 32'(rsp0_tag), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    step();

    // Single add after reset.
    req0_valid = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req0_ready), 32'd1);
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd3);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp0_valid), 32'd1);
    chk("single_rsp_result", rsp0_result, 32'd8);
    chk("single_rsp_tag", 32'(rsp0_tag), 32'd2);
    chk("single_op_count", 32'(op_count), 32'd1);
    step();

    // Idle: ALU inputs zeroed, counter frozen.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_alu_a", alu_a, 32'd0);
      chk("idle_alu_b", alu_b, 32'd0);
      chk("idle_alu_code", 32'(alu_code), 32'd0);
      chk("idle_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("idle_op_count", 32'(op_count), 32'd1);
      step();
    end

    // Table-driven round-robin: port 0 sub 10-4, port 1 slt -1<1.
    req0_a = 32'd10; req0_b = 32'd4; req0_code = 4'b0001; req0_tag = 2'd1;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_code = 4'b1001; req1_tag = 2'd3;
    cnt_exp = 16'd1;
    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      rsp0_ready = tbl[i].rr0; rsp1_ready = tbl[i].rr1;
      @(negedge clk);
      chk("rr_ready0", 32'(req0_ready), 32'(tbl[i].e0));
      chk("rr_ready1", 32'(req1_ready), 32'(tbl[i].e1));
      chk("rr_op_count", 32'(op_count), 32'(cnt_exp));
      if (tbl[i].e0) chk("rr_alu_code0", 32'(alu_code), 32'd1);
      if (tbl[i].e1) chk("rr_alu_code1", 32'(alu_code), 32'd9);
      if (tbl[i].e0 || tbl[i].e1) cnt_exp = cnt_exp + 16'd1;
      step();
    end

    // Backpressure on port 1 while it holds 1<<4.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd4; req1_code = 4'b0010; req1_tag = 2'd0;
    @(negedge clk);
    chk("bp_first_accept", 32'(req1_ready), 32'd1);
    step();
    rsp1_ready = 1'b0;
    req0_valid = 1'b1;
    req1_a = 32'd3; req1_tag = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready1_low", 32'(req1_ready), 32'd0);
      chk("bp_ready0_high", 32'(req0_ready), 32'd1);
      chk("bp_hold_valid", 32'(rsp1_valid), 32'd1);
      chk("bp_hold_result", rsp1_result, 32'h10);
      chk("bp_hold_tag", 32'(rsp1_tag), 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready1", 32'(req1_ready), 32'd1);
    chk("bp_release_ready0", 32'(req0_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", 32'(rsp1_valid), 32'd1);
    chk("bp_new_result", rsp1_result, 32'h30);
    chk("bp_new_tag", 32'(rsp1_tag), 32'd2);
    chk("bp_op_count", 32'(op_count), 32'd17);
    step();

    // Reset while a port 0 result is stalled.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_code = 4'b0000; req0_tag = 2'd1;
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("midrst_tie_ready0", 32'(req0_ready), 32'd1);
    chk("midrst_tie_ready1", 32'(req1_ready), 32'd0);
    step();

    // Counter wrap: 17 accepts, 4-bit counter lands on 1.
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 17; i++) step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wrap_op_count16", 32'(op_count), 32'd17);
    chk("wrap_op_count4", 32'(op_count4), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single EX-stage ALU between two requesters, for example the main issue path (port 0) and an address/branch helper path (port 1). Each requester hands over operands, an ALUCode and a tag on a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand and ALUCode inputs, and registers each result into a one-entry response buffer per requester. Responses are returned on a valid/ready handshake with the tag unchanged.

Parameters:
TAGW, 2, width of the requester tag carried through with each operation
CNTW, 16, width of the accepted-operation counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  32  port 0 operand A
req0_b  input  32  port 0 operand B
req0_code  input  4  port 0 ALUCode
req0_tag  input  TAGW  port 0 tag
req1_valid, req1_ready, req1_a, req1_b, req1_code, req1_tag  same as port 0, for port 1
alu_a  output  32  operand A driven to the ALU
alu_b  output  32  operand B driven to the ALU
alu_code  output  4  ALUCode driven to the ALU
alu_result  input  32  combinational ALU result
rsp0_valid  output  1  port 0 result valid
rsp0_ready  input  1  port 0 consumer accepts the result
rsp0_result  output  32  port 0 result
rsp0_tag  output  TAGW  tag of the port 0 result
rsp1_valid, rsp1_ready, rsp1_result, rsp1_tag  same as port 0, for port 1
op_count  output  CNTW  number of operations accepted; wraps

Behaviour:
- Reset (synchronous, active-high):
  - rspN_valid=0, rspN_result=0, rspN_tag=0.
  - op_count=0.
  - last_grant=1, so port 0 wins the first tie.
  - Accepted but undelivered results are discarded. A request presented in the reset cycle is not accepted.
- Eligibility: portN is eligible when reqN_valid=1 and its response slot is free or draining, i.e. (!rspN_valid || rspN_ready).
- Grant is combinational within the same cycle:
  - Neither port eligible: no grant.
  - One port eligible: grant that port.
  - Both eligible: grant the port that differs from last_grant.
- last_grant updates only in a cycle with a grant. No grant leaves it unchanged.
- reqN_ready = (grant==N) and is never asserted during reset.
- reqN_ready depends on both valids and on the response state. Requesters must not make valid depend on ready. Once valid is asserted, operands, code and tag are held until ready.
- ALU drive:
  - Granted: alu_a/alu_b/alu_code = the granted port's fields.
  - No grant: alu_a=0, alu_b=0, alu_code=4'b0000 (add), so the ALU inputs are deterministic.
- ALUCode values 4'b1011-4'b1111 pass through unchecked. The returned result is whatever the ALU produces.
- Capture: on an accept cycle, at the clock edge:
  - rspN_result <= alu_result, rspN_tag <= reqN_tag, rspN_valid <= 1.
  - Latency is exactly 1 cycle from accept to rspN_valid.
- Hold: while rspN_valid=1 and rspN_ready=0, result and tag stay stable and port N is not eligible.
- Drain: rspN_valid=1 with rspN_ready=1 and no new accept for N gives rspN_valid <= 0.
- Drain and fill in the same cycle: the new result and tag replace the old ones and rspN_valid stays 1. This sustains one op per cycle per port.
- At most one accept per cycle in total.
- op_count increments by 1 per accept, modulo 2^CNTW (0xFFFF -> 0x0000).
- Throughput with both ports continuously valid and both consumers always ready: accepts alternate 0,1,0,1 with no idle cycles.

Test Plan:
- Reset then single op: after reset, port 0 sends a=5, b=3, code=0000, tag=2 -> req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp0_result=8, rsp0_tag=2; op_count=1.
- Round-robin tie: both valid continuously; port 0 sends sub 10-4, port 1 sends slt (1001) a=0xFFFFFFFF, b=1; both rsp_ready=1 -> grants 0,1,0,1; rsp0_result=6, rsp1_result=1; no idle cycle over 8 cycles.
- Backpressure: rsp1_ready=0 while rsp1 holds a result (sll 1<<4 = 0x10); port 1 keeps valid -> req1_ready=0 every cycle; rsp1_result stays 0x10; port 0 is granted every cycle. Raise rsp1_ready -> port 1 is accepted in that same cycle, and the new result appears the next cycle with rsp1_valid held at 1.
- Idle drive: no requests -> alu_a=0, alu_b=0, alu_code=0000; op_count unchanged; last_grant unchanged.
- Reset mid-operation: accept on port 0, then assert reset on the next edge while rsp0_ready=0 -> rsp0_valid=0, op_count=0; the first post-reset tie is granted to port 0.
- Counter wrap: with CNTW=4, perform 17 accepts -> op_count=1.
